// File: rtl/pattern_gen_multi_if.sv
// Frame bus between the pattern generator (master) and its consumer (slave).
// Handshake: a frame transfers on any rising edge where pattern_valid && out_ready;
// the master holds pattern_data/step_wrap stable while pattern_valid is high and not accepted.
interface pattern_gen_multi_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  logic [ROWS*COLS-1:0] pattern_data;
  logic                 pattern_valid;
  logic                 step_wrap;
  logic                 out_ready;

  modport master (
    output pattern_data,
    output pattern_valid,
    output step_wrap,
    input  out_ready
  );

  modport slave (
    input  pattern_data,
    input  pattern_valid,
    input  step_wrap,
    output out_ready
  );
endinterface

// File: rtl/pattern_gen_multi.sv
// Lamp-matrix pattern generator: row/column/dot scans and blink, paced by a step divider.
// Optional macro PATGEN_PWM_EN adds brightness PWM gating of the lamp outputs.
module pattern_gen_multi #(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [7:0]           speed,
  input  logic [7:0]           brightness,
  pattern_gen_multi_if.master  bus,
  output logic [ROWS*COLS-1:0] lamp
);

  localparam int NPIX = ROWS * COLS;
  localparam int IW   = $clog2(NPIX);

  typedef enum logic [1:0] {
    ROW_SCAN = 2'd0,
    COL_SCAN = 2'd1,
    DOT_SCAN = 2'd2,
    BLINK    = 2'd3
  } mode_e;

  mode_e             r_mode;
  logic [7:0]        r_div;
  logic [IW-1:0]     r_idx;
  logic [NPIX-1:0]   r_data;
  logic              r_valid;
  logic              r_wrap;
  logic [NPIX-1:0]   r_lamp;

  logic              w_mode_chg;
  logic              w_stall;
  logic              w_accept;
  logic [IW-1:0]     w_last;
  logic [NPIX-1:0]   w_frame;

  assign w_mode_chg = (mode_e'(mode) != r_mode);
  assign w_stall    = r_valid && !bus.out_ready;
  assign w_accept   = r_valid && bus.out_ready;

  always_comb begin
    w_last = IW'(1);
    case (r_mode)
      ROW_SCAN: w_last = IW'(ROWS - 1);
      COL_SCAN: w_last = IW'(COLS - 1);
      DOT_SCAN: w_last = IW'(NPIX - 1);
      BLINK:    w_last = IW'(1);
      default:  w_last = IW'(1);
    endcase
  end

  // Frame for the current step index, bit r*COLS+c is row r, column c.
  always_comb begin
    w_frame = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        case (r_mode)
          ROW_SCAN: w_frame[r*COLS+c] = (IW'(r) == r_idx);
          COL_SCAN: w_frame[r*COLS+c] = (IW'(c) == r_idx);
          DOT_SCAN: w_frame[r*COLS+c] = (IW'(r*COLS+c) == r_idx);
          BLINK:    w_frame[r*COLS+c] = (r_idx == '0);
          default:  w_frame[r*COLS+c] = 1'b0;
        endcase
      end
    end
  end

  // An accepted frame clears valid; a step event in the same cycle overrides with the new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode  <= mode_e'(mode);
      r_div   <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b0;
        r_wrap  <= 1'b0;
      end
      if (w_mode_chg) begin
        r_mode <= mode_e'(mode);
        r_idx  <= '0;
        r_div  <= '0;
      end else if (en && !w_stall) begin
        if (r_div == speed) begin
          r_div   <= '0;
          r_data  <= w_frame;
          r_valid <= 1'b1;
          r_wrap  <= (r_idx == '0);
          r_idx   <= (r_idx == w_last) ? '0 : r_idx + IW'(1);
        end else begin
          r_div <= r_div + 8'd1;
        end
      end
    end
  end

`ifdef PATGEN_PWM_EN
  logic [7:0] r_pwm;
  logic       w_pwm_on;

  assign w_pwm_on = (r_pwm < brightness) || (brightness == 8'hFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm  <= '0;
      r_lamp <= '0;
    end else begin
      if (en) begin
        r_pwm <= r_pwm + 8'd1;
      end
      r_lamp <= (en && w_pwm_on) ? r_data : '0;
    end
  end
`else
  logic w_unused_brightness;
  assign w_unused_brightness = ^brightness;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lamp <= '0;
    end else begin
      r_lamp <= en ? r_data : '0;
    end
  end
`endif

  assign bus.pattern_data  = r_data;
  assign bus.pattern_valid = r_valid;
  assign bus.step_wrap     = r_wrap;
  assign lamp              = r_lamp;

endmodule

// File: tb/tb_pattern_gen_multi.sv
// Directed bench for pattern_gen_multi (8x8): scans, blink, stall, mode change, en, reset.
module tb_pattern_gen_multi;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int NPIX = ROWS * COLS;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [1:0]      mode;
  logic [7:0]      speed;
  logic [7:0]      brightness;
  logic [NPIX-1:0] lamp;

  int n_checks = 0;
  int n_fail   = 0;
  logic [NPIX-1:0] exp_q[$];

  pattern_gen_multi_if #(.ROWS(ROWS), .COLS(COLS)) bus_if ();

  pattern_gen_multi #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .speed      (speed),
    .brightness (brightness),
    .bus        (bus_if.master),
    .lamp       (lamp)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [NPIX-1:0] got, input logic [NPIX-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [NPIX-1:0] row_frame(input int k);
    logic [NPIX-1:0] f;
    f = '0;
    for (int c = 0; c < COLS; c++) f[k*COLS+c] = 1'b1;
    return f;
  endfunction

  function automatic logic [NPIX-1:0] col_frame(input int k);
    logic [NPIX-1:0] f;
    f = '0;
    for (int r = 0; r < ROWS; r++) f[r*COLS+k] = 1'b1;
    return f;
  endfunction

  // ---------------- drivers ----------------
  task automatic apply_reset(input logic [1:0] m);
    rst  = 1'b1;
    en   = 1'b0;
    mode = m;
    repeat (2) tick();
    check("rst_valid", {63'd0, bus_if.pattern_valid}, '0);
    check("rst_data",  bus_if.pattern_data, '0);
    check("rst_wrap",  {63'd0, bus_if.step_wrap}, '0);
    check("rst_lamp",  lamp, '0);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    rst = 1'b1; en = 1'b0; mode = 2'd0; speed = 8'd0; brightness = 8'hFF;
    bus_if.out_ready = 1'b1;

    // Row scan at full speed
    apply_reset(2'd0);
    en = 1'b1;
    tick();
    check("row0_data",  bus_if.pattern_data, 64'h00000000000000FF);
    check("row0_valid", {63'd0, bus_if.pattern_valid}, 64'd1);
    check("row0_wrap",  {63'd0, bus_if.step_wrap}, 64'd1);
    check("row0_lamp",  lamp, '0);
    tick();
    check("row1_data", bus_if.pattern_data, 64'h000000000000FF00);
    check("row1_wrap", {63'd0, bus_if.step_wrap}, '0);
    check("row1_lamp", lamp, 64'h00000000000000FF);
    for (int k = 2; k < ROWS; k++) begin
      tick();
      check("rowk_data", bus_if.pattern_data, row_frame(k));
    end
    tick();
    check("rowwrap_data", bus_if.pattern_data, row_frame(0));
    check("rowwrap_wrap", {63'd0, bus_if.step_wrap}, 64'd1);

    // en=0 holds frame and step, forces lamp low; pending frame still accepted
    en = 1'b0;
    tick();
    check("en0_data",  bus_if.pattern_data, row_frame(0));
    check("en0_valid", {63'd0, bus_if.pattern_valid}, '0);
    check("en0_lamp",  lamp, '0);
    tick();
    check("en0_hold", bus_if.pattern_data, row_frame(0));
    en = 1'b1;
    tick();
    check("en1_resume", bus_if.pattern_data, row_frame(1));

    // speed=3: one frame every 4 cycles, 9th frame equals 1st
    speed = 8'd3;
    apply_reset(2'd0);
    en = 1'b1;
    repeat (3) tick();
    check("spd_idle", {63'd0, bus_if.pattern_valid}, '0);
    tick();
    check("spd_f0", bus_if.pattern_data, row_frame(0));
    check("spd_f0_wrap", {63'd0, bus_if.step_wrap}, 64'd1);
    for (int k = 1; k <= 8; k++) exp_q.push_back(row_frame(k % ROWS));
    for (int f = 1; f <= 8; f++) begin
      logic [NPIX-1:0] e;
      repeat (3) tick();
      check("spd_gap", {63'd0, bus_if.pattern_valid}, '0);
      tick();
      e = exp_q.pop_front();
      check("spd_frame", bus_if.pattern_data, e);
      check("spd_wrap", {63'd0, bus_if.step_wrap}, (f == 8) ? 64'd1 : 64'd0);
    end

    // Blink
    speed = 8'd0;
    apply_reset(2'd3);
    en = 1'b1;
    tick();
    check("blink0", bus_if.pattern_data, {NPIX{1'b1}});
    check("blink0_wrap", {63'd0, bus_if.step_wrap}, 64'd1);
    tick();
    check("blink1", bus_if.pattern_data, '0);
    check("blink1_wrap", {63'd0, bus_if.step_wrap}, '0);
    tick();
    check("blink2", bus_if.pattern_data, {NPIX{1'b1}});

    // Dot scan with stalled consumer
    bus_if.out_ready = 1'b0;
    apply_reset(2'd2);
    en = 1'b1;
    tick();
    check("dot0_data", bus_if.pattern_data, 64'h1);
    repeat (5) tick();
    check("stall_data",  bus_if.pattern_data, 64'h1);
    check("stall_valid", {63'd0, bus_if.pattern_valid}, 64'd1);
    check("stall_lamp",  lamp, 64'h1);
    bus_if.out_ready = 1'b1;
    tick();
    check("dot1_data", bus_if.pattern_data, 64'h2);
    check("dot1_wrap", {63'd0, bus_if.step_wrap}, '0);

    // Mode change ROW_SCAN -> COL_SCAN at step 3
    apply_reset(2'd0);
    en = 1'b1;
    repeat (3) tick();
    check("mc_pre", bus_if.pattern_data, row_frame(2));
    mode = 2'd1;
    tick();
    check("mc_hold", bus_if.pattern_data, row_frame(2));
    tick();
    check("mc_col0", bus_if.pattern_data, 64'h0101010101010101);
    check("mc_col0_wrap", {63'd0, bus_if.step_wrap}, 64'd1);
    tick();
    check("mc_col1", bus_if.pattern_data, col_frame(1));

    // Reset mid-run with a pending frame
    apply_reset(2'd0);
    en = 1'b1;
    repeat (2) tick();
    bus_if.out_ready = 1'b0;
    tick();
    check("mr_pending", bus_if.pattern_data, row_frame(1));
    rst = 1'b1;
    tick();
    check("mr_valid", {63'd0, bus_if.pattern_valid}, '0);
    check("mr_data",  bus_if.pattern_data, '0);
    check("mr_lamp",  lamp, '0);
    tick();
    rst = 1'b0;
    bus_if.out_ready = 1'b1;
    tick();
    check("mr_first", bus_if.pattern_data, row_frame(0));
    check("mr_first_wrap", {63'd0, bus_if.step_wrap}, 64'd1);

`ifdef PATGEN_PWM_EN
    // PWM duty over full 256-cycle windows, blink step 0 held
    bus_if.out_ready = 1'b0;
    brightness = 8'h40;
    apply_reset(2'd3);
    en = 1'b1;
    repeat (2) tick();
    cnt = 0;
    repeat (256) begin
      tick();
      if (lamp == {NPIX{1'b1}}) cnt++;
    end
    check("pwm_40", 64'(cnt), 64'd64);
    brightness = 8'h00;
    repeat (2) tick();
    cnt = 0;
    repeat (256) begin
      tick();
      if (lamp != '0) cnt++;
    end
    check("pwm_00", 64'(cnt), 64'd0);
    brightness = 8'hFF;
    repeat (2) tick();
    cnt = 0;
    repeat (256) begin
      tick();
      if (lamp == {NPIX{1'b1}}) cnt++;
    end
    check("pwm_ff", 64'(cnt), 64'd256);
`else
    cnt = 0;
`endif

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_gen_multi.md
PATTERN_GEN_MULTI -- requirements
Module: pattern_gen_multi

Interface
REQ-001 SHALL have parameter ROWS, default 8, number of lamp rows (legal range 2..16).
REQ-002 SHALL have parameter COLS, default 8, number of lamp columns (legal range 2..16).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  run enable.
REQ-006 SHALL have port mode  input  2  pattern select: 0 ROW_SCAN, 1 COL_SCAN, 2 DOT_SCAN, 3 BLINK.
REQ-007 SHALL have port speed  input  8  step period minus one, in clk cycles.
REQ-008 SHALL have port brightness  input  8  PWM duty.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the current frame.
REQ-010 SHALL have port pattern_data  output  ROWS*COLS  registered frame; bit r*COLS+c is row r, column c.
REQ-011 SHALL have port pattern_valid  output  1  frame pending.
REQ-012 SHALL have port step_wrap  output  1  high while the pending frame is step 0.
REQ-013 SHALL have port lamp  output  ROWS*COLS  brightness-gated pixel drive.

Function
REQ-014 Divider div_cnt (8 b): when en=1 and not stalled, div_cnt==speed produces a step event and clears div_cnt; otherwise div_cnt increments; speed=0 gives a step event every cycle.
REQ-015 Step event: the frame for step_idx SHALL be registered onto pattern_data on the next edge, with pattern_valid=1 and step_wrap=(step_idx==0); step_idx then advances modulo NSTEPS(mode).
REQ-016 NSTEPS and frame content: ROW_SCAN NSTEPS=ROWS, row k all ones; COL_SCAN NSTEPS=COLS, column k all ones; DOT_SCAN NSTEPS=ROWS*COLS, only bit k set; BLINK NSTEPS=2, step 0 all ones, step 1 all zeros.
REQ-017 Handshake: pattern_valid stays high until sampled with out_ready=1; on accept it clears next edge unless a step event occurs in the same cycle, in which case it stays high with the new frame.
REQ-018 Stall: pattern_valid=1 and out_ready=0 SHALL hold div_cnt, step_idx and pattern_data; no frame is dropped or skipped.
REQ-019 Mode change: the mode input SHALL be compared against a latched mode each cycle; on mismatch the block latches the new mode, clears step_idx and div_cnt, and leaves pattern_data and pattern_valid unchanged; the next step event emits step 0 of the new mode.
REQ-020 en=0: div_cnt, step_idx, pattern_data and pattern_valid hold; lamp is forced to 0; the handshake still accepts a pending frame.
REQ-021 Simultaneous mode change and step event: the mode change wins and no frame is emitted that cycle.

Reset
REQ-022 rst=1 SHALL on the next edge set pattern_data=0, pattern_valid=0, step_wrap=0, lamp=0, div_cnt=0, step_idx=0 and the latched mode = mode input.
REQ-023 Reset asserted mid-operation SHALL abandon any pending frame; after release the first step event emits step 0.

Configuration
REQ-024 Macro PATGEN_PWM_EN defined: free-running 8 b pwm_cnt runs while en=1; lamp = pattern_data AND (pwm_cnt<brightness OR brightness==255); lamp is registered (1-cycle latency).
REQ-025 Macro PATGEN_PWM_EN undefined: pwm_cnt is absent, brightness is ignored, and lamp = pattern_data registered when en=1, else 0.

Verification
REQ-026 ROWS=COLS=8, rst, then en=1, mode=0, speed=0, out_ready=1 -> one edge later pattern_valid=1, pattern_data=64'h00000000000000FF, step_wrap=1; next frame 64'h000000000000FF00.
REQ-027 speed=3, out_ready=1, mode=0 -> a new frame every 4 cycles; the 9th frame equals the 1st, with step_wrap=1.
REQ-028 mode=2, speed=0, out_ready=0 -> pattern_data=64'h1 and pattern_valid=1 held indefinitely; raise out_ready -> next edge pattern_data=64'h2.
REQ-029 Mode change 0->1 while at ROW_SCAN step 3 -> next emitted frame 64'h0101010101010101, with step_wrap=1.
REQ-030 PATGEN_PWM_EN, mode=3 step 0, brightness=8'h40 -> each lamp bit high for exactly 64 of every 256 cycles; brightness=0 -> lamp=0; brightness=8'hFF -> lamp all ones continuously.
REQ-031 rst pulsed for 2 cycles mid-run with a frame pending -> next edge pattern_valid=0, pattern_data=0, lamp=0; after release the first frame is step 0.
